// File: rtl/cv32e40p_secded_pkg.sv
// Shared Hsiao (39,32) SEC-DED definitions.
// Encoder and decoder both take the H matrix from here.
package cv32e40p_secded_pkg;

  localparam int SECDED_K = 32;
  localparam int SECDED_R = 7;
  localparam int SECDED_N = SECDED_K + SECDED_R;

  typedef logic [SECDED_R-1:0][SECDED_N-1:0] secded_h_t;
  typedef logic [SECDED_N-1:0][SECDED_R-1:0] secded_ht_t;

  // Row i at index i; bit 38 of each row is the MSB.
  localparam secded_h_t SECDED_H = {
    39'b001100100101010011001010010101001000000,
    39'b010010011001001100101001010100100100000,
    39'b101001100010110010100101010010100010000,
    39'b100110010101001010010100101010100001000,
    39'b011001001100101001010011001010010000100,
    39'b010100110010100101001100101001010000010,
    39'b100011001010010100110010100101010000001
  };

  function automatic secded_ht_t secded_transpose(secded_h_t h);
    secded_ht_t ht;
    for (int c = 0; c < SECDED_N; c++) begin
      for (int r = 0; r < SECDED_R; r++) begin
        ht[c][r] = h[r][c];
      end
    end
    return ht;
  endfunction

  localparam secded_ht_t SECDED_HT = secded_transpose(SECDED_H);

  typedef enum logic [2:0] {
    SECDED_NONE = 3'b001,
    SECDED_SEC  = 3'b010,
    SECDED_DED  = 3'b100
  } secded_e;

endpackage

// File: rtl/cv32e40p_hsiao_secded_syndrome.sv
// Combinational Hsiao syndrome generator.
// DATA_ONLY masks the check bits, giving the encoder's parity.
module cv32e40p_hsiao_secded_syndrome
  import cv32e40p_secded_pkg::*;
#(
  parameter bit DATA_ONLY = 1'b0
) (
  input  logic [SECDED_N-1:0] cw,
  output logic [SECDED_R-1:0] syndrome
);

  localparam logic [SECDED_N-1:0] MASK = DATA_ONLY ?
    {{SECDED_K{1'b1}}, {SECDED_R{1'b0}}} :
    {SECDED_N{1'b1}};

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < SECDED_R; i++) begin
      syndrome[i] = ^(cw & SECDED_H[i] & MASK);
    end
  end

endmodule

// File: rtl/cv32e40p_hsiao_secded_decoder_pipe.sv
// Two-stage Hsiao SEC-DED checker/corrector with
// valid/ready backpressure and saturating error counters.
module cv32e40p_hsiao_secded_decoder_pipe
  import cv32e40p_secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int R_BITS     = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH+R_BITS-1:0] data_dec_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_WIDTH-1:0]        data_dec_o,
  output logic [2:0]                   secded_o,
  output logic [5:0]                   err_pos_o,
  output logic [R_BITS-1:0]            syndrome_o,
  output logic [CNT_WIDTH-1:0]         sec_cnt_o,
  output logic [CNT_WIDTH-1:0]         ded_cnt_o,
  output logic                         fatal_o,
  input  logic                         clear_i
);

  localparam int N = DATA_WIDTH + R_BITS;

  logic          s1_valid;
  logic [N-1:0]  s1_cw;
  logic [R_BITS-1:0] s1_syn;
  logic [R_BITS-1:0] syn;
  logic          s2_valid;
  secded_e       s2_cls;

  logic          s2_load;
  logic          in_xfer;
  logic          out_xfer;

  secded_e       cls;
  logic [5:0]    pos;
  logic [N-1:0]  flip;
  logic [N-1:0]  corr;
  logic          found;

  cv32e40p_hsiao_secded_syndrome #(
    .DATA_ONLY(1'b0)
  ) u_syndrome (
    .cw      (data_dec_i),
    .syndrome(syn)
  );

  assign s2_load  = !s2_valid || ready_i;
  assign ready_o  = !s1_valid || s2_load;
  assign in_xfer  = valid_i && ready_o;
  assign valid_o  = s2_valid;
  assign out_xfer = valid_o && ready_i;
  assign secded_o = s2_cls;

  // A non-zero syndrome that matches no column is uncorrectable.
  always_comb begin
    cls   = SECDED_NONE;
    pos   = '0;
    flip  = '0;
    found = 1'b0;
    if (s1_syn != '0) begin
      cls = SECDED_DED;
      for (int j = 0; j < N; j++) begin
        if (!found && s1_syn == SECDED_HT[j]) begin
          found   = 1'b1;
          cls     = SECDED_SEC;
          pos     = 6'(j);
          flip[j] = 1'b1;
        end
      end
    end
    corr = s1_cw ^ flip;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_cw      <= '0;
      s1_syn     <= '0;
      s2_valid   <= 1'b0;
      s2_cls     <= SECDED_NONE;
      data_dec_o <= '0;
      err_pos_o  <= '0;
      syndrome_o <= '0;
    end else begin
      if (ready_o) s1_valid <= valid_i;
      if (in_xfer) begin
        s1_cw  <= data_dec_i;
        s1_syn <= syn;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        data_dec_o <= corr[N-1:R_BITS];
        s2_cls     <= cls;
        err_pos_o  <= pos;
        syndrome_o <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
      fatal_o   <= 1'b0;
    end else if (out_xfer) begin
      if (s2_cls == SECDED_SEC && sec_cnt_o != '1)
        sec_cnt_o <= sec_cnt_o + 1'b1;
      if (s2_cls == SECDED_DED) begin
        if (ded_cnt_o != '1)
          ded_cnt_o <= ded_cnt_o + 1'b1;
        fatal_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_hsiao_secded_decoder_pipe.sv
// Directed bench for the pipelined Hsiao SEC-DED decoder.
// A second instance with 2-bit counters checks saturation.
module tb_cv32e40p_hsiao_secded_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic        clear_i;
  logic [38:0] data_dec_i;

  logic        ready_o, valid_o, fatal_o;
  logic [31:0] data_dec_o;
  logic [2:0]  secded_o;
  logic [5:0]  err_pos_o;
  logic [6:0]  syndrome_o;
  logic [15:0] sec_cnt_o, ded_cnt_o;

  logic        ready2, valid2, fatal2;
  logic [31:0] data2;
  logic [2:0]  secded2;
  logic [5:0]  err_pos2;
  logic [6:0]  syn2;
  logic [1:0]  sec_cnt2, ded_cnt2;

  int passed = 0;
  int total  = 0;

  logic [38:0] hm [7];
  logic [38:0] cw_good;
  logic [38:0] sw [5];

  always #5 clk = ~clk;

  cv32e40p_hsiao_secded_decoder_pipe dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready_o),
    .data_dec_i(data_dec_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .data_dec_o(data_dec_o), .secded_o(secded_o),
    .err_pos_o(err_pos_o), .syndrome_o(syndrome_o),
    .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o),
    .fatal_o(fatal_o), .clear_i(clear_i)
  );

  cv32e40p_hsiao_secded_decoder_pipe #(
    .CNT_WIDTH(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .ready_o(ready2),
    .data_dec_i(data_dec_i),
    .valid_o(valid2), .ready_i(ready_i),
    .data_dec_o(data2), .secded_o(secded2),
    .err_pos_o(err_pos2), .syndrome_o(syn2),
    .sec_cnt_o(sec_cnt2), .ded_cnt_o(ded_cnt2),
    .fatal_o(fatal2), .clear_i(clear_i)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic logic [38:0] enc(logic [31:0] d);
    logic [38:0] c;
    c = {d, 7'b0};
    for (int i = 0; i < 7; i++) c[i] = ^({d, 7'b0} & hm[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the word sitting in S2 with valid_o high.
  task automatic send(logic [38:0] cw);
    valid_i    = 1'b1;
    data_dec_i = cw;
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    int sent, got;
    bit dropped, held_v;
    logic [31:0] held;

    hm[0] = 39'b100011001010010100110010100101010000001;
    hm[1] = 39'b010100110010100101001100101001010000010;
    hm[2] = 39'b011001001100101001010011001010010000100;
    hm[3] = 39'b100110010101001010010100101010100001000;
    hm[4] = 39'b101001100010110010100101010010100010000;
    hm[5] = 39'b010010011001001100101001010100100100000;
    hm[6] = 39'b001100100101010011001010010101001000000;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    clear_i = 1'b0; data_dec_i = '0;
    tick(); tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", data_dec_o, 0);
    chk("rst_secded", secded_o, 3'b001);
    chk("rst_errpos", err_pos_o, 0);
    chk("rst_syn", syndrome_o, 0);
    chk("rst_cnt", {sec_cnt_o, ded_cnt_o}, 0);
    chk("rst_fatal", fatal_o, 0);
    rst = 1'b0;

    send(39'h0);
    chk("zero_valid", valid_o, 1);
    chk("zero_data", data_dec_o, 0);
    chk("zero_secded", secded_o, 3'b001);
    chk("zero_syn", syndrome_o, 0);
    tick();
    chk("zero_drain", valid_o, 0);
    chk("zero_cnt", {sec_cnt_o, ded_cnt_o}, 0);

    send(39'h20);
    chk("b5_data", data_dec_o, 0);
    chk("b5_secded", secded_o, 3'b010);
    chk("b5_errpos", err_pos_o, 5);
    chk("b5_syn", syndrome_o, 7'b0100000);
    tick();
    chk("b5_seccnt", sec_cnt_o, 1);

    send(39'h100400);
    chk("ded_secded", secded_o, 3'b100);
    chk("ded_data", data_dec_o, 32'h2008);
    chk("ded_errpos", err_pos_o, 0);
    chk("ded_syn", syndrome_o, 7'h2d);
    chk("ded_fatal_pre", fatal_o, 0);
    tick();
    chk("ded_cnt", ded_cnt_o, 1);
    chk("ded_fatal", fatal_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_cnt", {sec_cnt_o, ded_cnt_o}, 0);
    chk("clr_fatal", fatal_o, 0);
    chk("clr_cnt2", {sec_cnt2, ded_cnt2}, 0);

    cw_good = enc(32'hDEADBEEF);
    send(cw_good);
    chk("good_data", data_dec_o, 32'hDEADBEEF);
    chk("good_secded", secded_o, 3'b001);
    for (int b = 0; b < 39; b++) begin
      send(cw_good ^ (39'h1 << b));
      chk($sformatf("flip%0d_data", b),
          data_dec_o, 32'hDEADBEEF);
      chk($sformatf("flip%0d_pos", b), err_pos_o, b);
      chk($sformatf("flip%0d_cls", b), secded_o, 3'b010);
    end
    tick();
    chk("flip_seccnt", sec_cnt_o, 39);
    chk("sat_seccnt2", sec_cnt2, 2'd3);
    chk("flip_fatal", fatal_o, 0);

    for (int k = 0; k < 5; k++) sw[k] = enc(32'hA5A50000 + k);
    sent = 0; got = 0; dropped = 0; held_v = 0; held = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      ready_i    = !(c >= 2 && c <= 4);
      valid_i    = sent < 5;
      data_dec_i = sent < 5 ? sw[sent] : '0;
      #1;
      if (!ready_o) dropped = 1;
      if (valid_o && !ready_i) begin
        if (held_v) chk("hold_data", data_dec_o, held);
        held = data_dec_o; held_v = 1;
      end else held_v = 0;
      if (valid_o && ready_i) begin
        chk($sformatf("stream%0d", got), data_dec_o,
            32'hA5A50000 + got);
        got++;
      end
      if (valid_i && ready_o) sent++;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("stream_got", got, 5);
    chk("stream_sent", sent, 5);
    chk("stream_rdy_drop", dropped, 1);
    tick();
    chk("stream_drain", valid_o, 0);

    ready_i = 1'b0;
    valid_i = 1'b1; data_dec_i = cw_good ^ 39'h1;
    tick();
    data_dec_i = cw_good ^ 39'h2;
    tick();
    valid_i = 1'b0;
    chk("fly_valid", valid_o, 1);
    chk("fly_ready", ready_o, 0);
    rst = 1'b1;
    tick();
    chk("mrst_valid", valid_o, 0);
    chk("mrst_ready", ready_o, 1);
    chk("mrst_cnt", {sec_cnt_o, ded_cnt_o}, 0);
    rst = 1'b0; ready_i = 1'b1;
    tick(); tick(); tick();
    chk("mrst_empty", valid_o, 0);
    chk("mrst_cnt_after", sec_cnt_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
